// File: rtl/bram_stream_reader.sv
// Read engine for a 1-cycle-latency BRAM: sequences addresses, absorbs read latency and
// streams words over valid/ready with backpressure. Optional `READ_STRIDE_EN adds i_stride.
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 13,
    parameter int NB_ADDRESS = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_base_addr,
    input  logic [NB_ADDRESS:0]   i_length,
`ifdef READ_STRIDE_EN
    input  logic [NB_ADDRESS-1:0] i_stride,
`endif
    output logic [NB_ADDRESS-1:0] o_readAdd,
    input  logic [RAM_WIDTH-1:0]  i_memData,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int USE_W = CNT_W + 1;
    localparam logic [NB_ADDRESS:0] LEN_ONE = (NB_ADDRESS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Handshake: a beat transfers on a rising edge where o_valid && i_ready; o_valid never
    // drops and o_data never changes until that beat has transferred.
    state_t                state_q, state_d;
    logic [NB_ADDRESS-1:0] addr_q, addr_d;
    logic [NB_ADDRESS:0]   remain_q, remain_d;
    logic [1:0]            issue_q, issue_d;
    logic [1:0]            last_q, last_d;
    logic [RAM_WIDTH:0]    fifo_q [FIFO_DEPTH];
    logic [RAM_WIDTH:0]    fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  start_go, run_go, issue_last;
    logic                  push, pop, credit, head_last;
    logic [USE_W-1:0]      in_use;
    logic [RAM_WIDTH:0]    head;
    logic [NB_ADDRESS-1:0] step;

`ifdef READ_STRIDE_EN
    logic [NB_ADDRESS-1:0] stride_q, stride_d;

    always_comb begin
        stride_d = stride_q;
        if (start_go) stride_d = i_stride;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) stride_q <= '0;
        else          stride_q <= stride_d;
    end

    assign step = stride_q;
`else
    assign step = NB_ADDRESS'(1);
`endif

    // Words still inside the BRAM pipeline keep a reserved slot, so a push never overflows.
    assign in_use    = USE_W'(count_q) + USE_W'(issue_q[0]) + USE_W'(issue_q[1]);
    assign credit    = in_use < USE_W'(FIFO_DEPTH);
    assign start_go  = (state_q == S_IDLE) && i_start && (i_length != '0);
    assign run_go    = (state_q == S_RUN) && (remain_q != '0) && credit;
    assign head      = fifo_q[rd_ptr_q];
    assign head_last = head[RAM_WIDTH];
    assign push      = issue_q[1];
    assign pop       = (count_q != '0) && i_ready;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = (i_length == '0) ? S_DONE : S_RUN;
            S_RUN:   if ((remain_q == '0) || (run_go && remain_q == LEN_ONE)) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_DONE);
        o_dbg_state = state_q;
        o_readAdd   = addr_q;
        o_valid     = (count_q != '0);
        o_data      = o_valid ? head[RAM_WIDTH-1:0] : '0;
        o_last      = o_valid & head_last;
    end

    // The start edge itself issues the base address; RUN issues the rest.
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        issue_last = 1'b0;
        if (start_go) begin
            addr_d     = i_base_addr;
            remain_d   = i_length - LEN_ONE;
            issue_last = (i_length == LEN_ONE);
        end else if (run_go) begin
            addr_d     = addr_q + step;
            remain_d   = remain_q - LEN_ONE;
            issue_last = (remain_q == LEN_ONE);
        end
        issue_d = {issue_q[0], start_go | run_go};
        last_d  = {last_q[0], issue_last};
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {last_q[1], i_memData};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            addr_q   <= '0;
            remain_q <= '0;
            issue_q  <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
            issue_q  <= issue_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: BRAM model, ready shaper, queue-based reference.
module tb_bram_stream_reader;
  localparam int W     = 13;
  localparam int A     = 10;
  localparam int DEPTH = 1 << A;
  localparam int EW    = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [A-1:0] base_addr = '0;
  logic [A:0]   length = '0;
  logic [A-1:0] stride = '0;
  logic [A-1:0] rd_addr;
  logic [W-1:0] mem_data = '0;
  logic [W-1:0] o_data;
  logic         o_valid, o_last, o_busy, o_done;
  logic         i_ready = 1'b1;
  logic [1:0]   dbg_state;

  logic [W-1:0]  mem [DEPTH];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;
  int cyc = 0;
  int t0 = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit hold = 1'b0;
  logic [W-1:0] hold_data = '0;

  bram_stream_reader dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_start     (i_start),
    .i_base_addr (base_addr),
    .i_length    (length),
`ifdef READ_STRIDE_EN
    .i_stride    (stride),
`endif
    .o_readAdd   (rd_addr),
    .i_memData   (mem_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block and BRAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= mem[rd_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ready shaper: 0 = always ready, 1 = random with 10-cycle stalls, 2 = never ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) i_ready = 1'b1;
      else if (ready_mode == 2) i_ready = 1'b0;
      else if (stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        i_ready = 1'b0;
        stall_left = 9;
      end else i_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, hold_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("beat_data", o_data, mon_e[W-1:0]);
          check("beat_last", o_last, mon_e[W]);
          beats++;
        end
      end
      hold = o_valid && !i_ready;
      hold_data = o_data;
    end
  end

  // reference model: word i of a transfer is mem[(base + i*stride) mod depth]
  task automatic push_expected(input logic [A-1:0] b, input logic [A:0] l, input logic [A-1:0] s);
    int idx;
    logic lst;
    for (int i = 0; i < int'(l); i++) begin
      idx = (int'(b) + i * int'(s)) % DEPTH;
      lst = (i == int'(l) - 1);
      exp_q.push_back({lst, mem[idx]});
    end
  endtask

  task automatic start_xfer(input logic [A-1:0] b, input logic [A:0] l, input logic [A-1:0] s);
    @(posedge clk);
    #1;
    base_addr = b;
    length = l;
    stride = s;
    i_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    base_addr = A'($urandom);
    length = (A+1)'($urandom);
    stride = A'($urandom);
  endtask

  task automatic begin_xfer(input logic [A-1:0] b, input logic [A:0] l, input logic [A-1:0] s,
                            input int mode);
    logic [A-1:0] se;
`ifdef READ_STRIDE_EN
    se = s;
`else
    se = A'(1);
`endif
    ready_mode = mode;
    beats = 0;
    push_expected(b, l, se);
    start_xfer(b, l, se);
  endtask

  task automatic wait_done(input int max_cyc, output int rel);
    rel = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (o_done) begin
        rel = cyc - t0;
        break;
      end
    end
    if (rel < 0) check("done_timeout", 0, 1);
  endtask

  task automatic end_xfer(input logic [A:0] l, input int mode, output int rel);
    int len_i;
    len_i = int'(l);
    wait_done(len_i * 30 + 60, rel);
    if (mode == 0 && len_i > 0 && rel >= 0) check("done_latency", rel, len_i + 3);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("busy_after", o_busy, 0);
    check("beat_count", beats, len_i);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int rel;
    logic [A-1:0] rb, rs;
    logic [A:0] rl;
    int rm;

    for (int k = 0; k < DEPTH; k++) mem[k] = W'(k);

    #12;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_addr", rd_addr, 0);
    #10;
    rst_n = 1'b1;

    // base 0, length 8, full throughput with first-beat timing probes
    begin_xfer(A'(0), (A+1)'(8), A'(1), 0);
    @(negedge clk);
    check("lat_c1_addr", rd_addr, 0);
    check("lat_c1_valid", o_valid, 0);
    check("lat_c1_busy", o_busy, 1);
    @(negedge clk);
    check("lat_c2_valid", o_valid, 0);
    @(negedge clk);
    check("lat_c3_valid", o_valid, 1);
    check("lat_c3_data", o_data, 0);
    end_xfer((A+1)'(8), 0, rel);

    // wrap across the top of the address space
    begin_xfer(A'(1020), (A+1)'(6), A'(1), 0);
    end_xfer((A+1)'(6), 0, rel);

    // length 16 under random backpressure
    begin_xfer(A'($urandom), (A+1)'(16), A'(1), 1);
    end_xfer((A+1)'(16), 1, rel);

    // length 0: no beats, single done pulse
    begin_xfer(A'(33), (A+1)'(0), A'(1), 0);
    end_xfer((A+1)'(0), 0, rel);
    check("len0_done_early", (rel >= 1 && rel <= 2), 1);

    // length 1
    begin_xfer(A'(1023), (A+1)'(1), A'(1), 1);
    end_xfer((A+1)'(1), 1, rel);

    // second start while busy is ignored
    begin_xfer(A'(300), (A+1)'(16), A'(1), 1);
    repeat (4) @(posedge clk);
    #1;
    check("busy_at_second_start", o_busy, 1);
    base_addr = A'(100);
    length = (A+1)'(5);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    end_xfer((A+1)'(16), 1, rel);
    repeat (5) @(negedge clk);
    check("no_extra_beats", beats, 16);

    // asynchronous reset mid-transfer with words buffered
    begin_xfer(A'(200), (A+1)'(16), A'(1), 2);
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_valid", o_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_data", o_data, 0);
    check("arst_last", o_last, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_addr", rd_addr, 0);
    exp_q.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    begin_xfer(A'(5), (A+1)'(3), A'(1), 0);
    end_xfer((A+1)'(3), 0, rel);

`ifdef READ_STRIDE_EN
    begin_xfer(A'(0), (A+1)'(4), A'(32), 0);
    end_xfer((A+1)'(4), 0, rel);
    begin_xfer(A'(7), (A+1)'(3), A'(0), 0);
    end_xfer((A+1)'(3), 0, rel);
`endif

    // random transfers
    for (int t = 0; t < 8; t++) begin
      rb = A'($urandom);
      rl = (A+1)'($urandom_range(1, 40));
      rs = A'($urandom_range(0, DEPTH - 1));
      rm = $urandom_range(0, 1);
      begin_xfer(rb, rl, rs, rm);
      end_xfer(rl, rm, rel);
    end

    // full-depth transfer reads every word once
    begin_xfer(A'($urandom), (A+1)'(DEPTH), A'(1), 0);
    end_xfer((A+1)'(DEPTH), 0, rel);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
